// File: rtl/fpga_log_arbiter_pkg.sv
// fpga_log_arb_pkg: shared types and constants for the FPGA log arbiter.
//   arb_state_e     - arbiter state (idle / locked on a source for a line)
//   LOG_DROP_CNT_W  - width of the per-source saturating drop counters
//   LOG_EOL_DEFAULT - default line terminator (newline)
package fpga_log_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int         LOG_DROP_CNT_W  = 16;
  localparam logic [7:0] LOG_EOL_DEFAULT = 8'h0A;

endpackage

// File: rtl/fpga_log_arbiter_if.sv
// fpga_log_arbiter_if: write side of the shared log FIFO.
//   fifo_wr_en  - write strobe            (master -> slave)
//   fifo_din    - character               (master -> slave)
//   fifo_src_id - source of the character (master -> slave)
//   fifo_full   - FIFO full flag          (slave -> master)
interface fpga_log_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int CHAR_W  = 8
);
  localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic              fifo_wr_en;
  logic [CHAR_W-1:0] fifo_din;
  logic [IDW-1:0]    fifo_src_id;
  logic              fifo_full;

  modport master (output fifo_wr_en, fifo_din, fifo_src_id, input fifo_full);
  modport slave  (input fifo_wr_en, fifo_din, fifo_src_id, output fifo_full);
endinterface

// File: rtl/fpga_log_src_buf.sv
// fpga_log_src_buf: small per-source character FIFO.
//   clk, rst - clock, synchronous active-high reset (flushes the buffer)
//   push/din - write a character (no backpressure; dropped when full)
//   pop      - remove the head (only asserted when non-empty)
//   head     - oldest character, valid when !empty
//   empty    - no characters buffered
//   full     - BUF_DEPTH characters buffered
//   drop     - push lost this cycle (full and no simultaneous pop)
module fpga_log_src_buf #(
  parameter int CHAR_W    = 8,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [CHAR_W-1:0] din,
  output logic [CHAR_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic              drop
);
  localparam int AW = $clog2(BUF_DEPTH);

  logic [CHAR_W-1:0] mem_q [BUF_DEPTH];
  logic [AW:0]       wp_q, rp_q;
  logic              wr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  // A pop frees the head slot in the same cycle, so a full buffer still accepts.
  assign wr    = push && (!full || pop);
  assign drop  = push && full && !pop;
  assign head  = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (wr)  wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fpga_log_arbiter.sv
// fpga_log_arbiter: shares one log FIFO write port among NUM_SRC character
// sources. Grants are round-robin and held for a whole line (up to EOL_CHAR)
// or until LOCK_TIMEOUT idle cycles pass, so lines never interleave.
//   core_clk, srst - clock, synchronous active-high reset
//   src_valid/char - per-source character strobes (no backpressure)
//   fifo           - log FIFO write port (wr_en/din/src_id out, full in)
//   clr_stats      - clears drop counters and overflow flags
//   drop_cnt       - saturating per-source dropped-character counts
//   overflow       - sticky per-source drop flags
//   busy           - locked on a source or any buffer non-empty
module fpga_log_arbiter
  import fpga_log_arb_pkg::*;
#(
  parameter int                NUM_SRC      = 2,
  parameter int                CHAR_W       = 8,
  parameter int                BUF_DEPTH    = 4,
  parameter int                LOCK_TIMEOUT = 64,
  parameter logic [CHAR_W-1:0] EOL_CHAR     = CHAR_W'(LOG_EOL_DEFAULT)
) (
  input  logic                                    core_clk,
  input  logic                                    srst,
  input  logic [NUM_SRC-1:0]                      src_valid,
  input  logic [NUM_SRC-1:0][CHAR_W-1:0]          src_char,
  fpga_log_arbiter_if.master                      fifo,
  input  logic                                    clr_stats,
  output logic [NUM_SRC-1:0][LOG_DROP_CNT_W-1:0]  drop_cnt,
  output logic [NUM_SRC-1:0]                      overflow,
  output logic                                    busy
);
  localparam int IDW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
  typedef logic [IDW-1:0] id_t;

  arb_state_e                             state_q, state_d;
  id_t                                    grant_q, grant_d, last_q, last_d;
  logic [TMO_W-1:0]                       tmo_q, tmo_d;
  logic [NUM_SRC-1:0][LOG_DROP_CNT_W-1:0] drop_cnt_q;
  logic [NUM_SRC-1:0]                     overflow_q;

  logic [NUM_SRC-1:0]             empty, full, pop, drop;
  logic [NUM_SRC-1:0][CHAR_W-1:0] head;
  logic                           wr_en, pick_vld;
  id_t                            pick, idx;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fpga_log_src_buf #(.CHAR_W(CHAR_W), .BUF_DEPTH(BUF_DEPTH)) u_buf (
      .clk(core_clk), .rst(srst), .push(src_valid[i]), .pop(pop[i]),
      .din(src_char[i]), .head(head[i]), .empty(empty[i]), .full(full[i]),
      .drop(drop[i])
    );
    assign pop[i] = wr_en && (grant_q == id_t'(i));
  end

  // Round-robin: scan from farthest to nearest after last_q so the nearest
  // non-empty source is the one left in pick.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = id_t'((int'(last_q) + k) % NUM_SRC);
      if (!empty[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // fifo_full gates the pop in the same cycle, so the log FIFO never overflows.
  assign wr_en = (state_q == ARB_LOCKED) && !empty[grant_q] && !fifo.fifo_full;

  // State register
  always_ff @(posedge core_clk) begin
    if (srst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= id_t'(NUM_SRC - 1);
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_d = ARB_LOCKED;
          grant_d = pick;
          tmo_d   = '0;
        end
      end
      ARB_LOCKED: begin
        if (wr_en) begin
          tmo_d = '0;
          if (head[grant_q] == EOL_CHAR) begin
            state_d = ARB_IDLE;
            last_d  = grant_q;
          end
        end else if (empty[grant_q]) begin
          // Only starvation counts; a full-FIFO stall with data pending does not.
          if (tmo_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
            state_d = ARB_IDLE;
            last_d  = grant_q;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    fifo.fifo_wr_en  = wr_en;
    fifo.fifo_din    = wr_en ? head[grant_q] : '0;
    fifo.fifo_src_id = wr_en ? grant_q : '0;
    busy             = (state_q == ARB_LOCKED) || !(&empty);
  end

  // Drop statistics; clear wins over a same-cycle drop.
  always_ff @(posedge core_clk) begin
    if (srst || clr_stats) begin
      drop_cnt_q <= '0;
      overflow_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (drop[i]) begin
          overflow_q[i] <= 1'b1;
          if (drop_cnt_q[i] != '1) drop_cnt_q[i] <= drop_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign overflow = overflow_q;
endmodule
